// File: rtl/pwm_pkg.sv
// Shared PWM definitions: period, code width and limits, and the capture FSM
// state type used by the capture block and its benches.
package pwm_pkg;
   localparam int PWM_PERIOD = 256;
   localparam int PWM_W      = 8;
   localparam logic [PWM_W-1:0] PWM_MAX = 8'hFF;
   localparam logic [PWM_W-1:0] PWM_MIN = 8'h00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_RISE,
      ST_HIGH,
      ST_LOW,
      ST_STUCK_HI,
      ST_STUCK_LO
   } cap_state_e;

   // The generator holds the line high for code+1 cycles.
   function automatic logic [PWM_W-1:0] high_to_code(input int unsigned high_cnt);
      return (high_cnt == 0) ? PWM_MIN : PWM_W'(high_cnt - 1);
   endfunction
endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Multi-flop synchronizer for the PWM line with single-cycle rise/fall detect
// on the synchronized level.
module pwm_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic pulse,
   output logic s,
   output logic rise,
   output logic fall
);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   s_prev_q, s_prev_d;

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], pulse};
      s_prev_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '0;
         s_prev_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         s_prev_q <= s_prev_d;
      end
   end

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~s_prev_q;
   assign fall = ~s & s_prev_q;
endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of an asynchronous PWM line and
// recovers the generator's 8-bit duty code; stuck lines decode to FF / 00.
//
// state        | meaning
// IDLE         | after reset, waiting for a settled low before measuring
// WAIT_RISE    | line low, waiting for the rise that starts a measurement
// HIGH         | counting the high phase
// LOW          | high time latched, waiting for the rise that closes the period
// STUCK_HI     | line stuck high, FF published, waiting for a fall
// STUCK_LO     | line stuck low, 00 published, waiting for a rise
module pwm_capture #(
   parameter int SYNC_STAGES = 2,
   parameter int PWM_PERIOD  = 256,
   parameter int TIMEOUT     = 512
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pulse,
   output logic [7:0] pulse_width,
   output logic       valid,
   output logic       period_err
);
   import pwm_pkg::*;

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

   logic          s, rise, fall;
   logic          tmo_hit;
   cap_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] high_q, high_d;
   logic [7:0]    pw_q, pw_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;

   pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst   (rst),
      .pulse (pulse),
      .s     (s),
      .rise  (rise),
      .fall  (fall)
   );

   always_comb begin
      if (rise)                 cnt_d = CW'(1);
      else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
      else                      cnt_d = cnt_q + CW'(1);
   end

   // Fires only on the step into saturation, so once per stuck episode;
   // an edge in the same cycle takes priority.
   assign tmo_hit = (cnt_q == CNT_MAX - CW'(1)) && !rise && !fall;

   always_comb begin
      state_d = state_q;
      high_d  = high_q;
      pw_d    = pw_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!s && cnt_q > CW'(SYNC_STAGES)) begin
               state_d = ST_WAIT_RISE;
            end else if (s && tmo_hit) begin
               pw_d    = PWM_MAX;
               valid_d = 1'b1;
               state_d = ST_STUCK_HI;
            end
         end
         ST_WAIT_RISE: begin
            if (rise) begin
               state_d = ST_HIGH;
            end else if (tmo_hit) begin
               pw_d    = PWM_MIN;
               valid_d = 1'b1;
               state_d = ST_STUCK_LO;
            end
         end
         ST_HIGH: begin
            if (fall) begin
               high_d  = cnt_q;
               state_d = ST_LOW;
            end else if (tmo_hit) begin
               pw_d    = PWM_MAX;
               valid_d = 1'b1;
               state_d = ST_STUCK_HI;
            end
         end
         ST_LOW: begin
            if (rise) begin
               if (cnt_q == CW'(PWM_PERIOD)) begin
                  pw_d    = high_to_code(32'(high_q));
                  valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = ST_HIGH;
            end else if (tmo_hit) begin
               pw_d    = PWM_MIN;
               valid_d = 1'b1;
               state_d = ST_STUCK_LO;
            end
         end
         ST_STUCK_HI: if (fall) state_d = ST_WAIT_RISE;
         ST_STUCK_LO: if (rise) state_d = ST_HIGH;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         high_q  <= '0;
         pw_q    <= 8'h00;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         high_q  <= high_d;
         pw_q    <= pw_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign pulse_width = pw_q;
   assign valid       = valid_q;
   assign period_err  = err_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: drives PWM waveforms built from level/length segments
// and compares decoded events against an edge-time reference model.
module tb_pwm_capture;
   localparam int SYNC = 2;
   localparam int PER  = 256;
   localparam int TMO  = 512;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pulse = 1'b0;
   logic [7:0] pulse_width;
   logic       valid, period_err;

   pwm_capture #(.SYNC_STAGES(SYNC), .PWM_PERIOD(PER), .TIMEOUT(TMO)) dut (
      .clk         (clk),
      .rst         (rst),
      .pulse       (pulse),
      .pulse_width (pulse_width),
      .valid       (valid),
      .period_err  (period_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         err;
      logic [7:0] code;
      int         t;      // 0 = timing not checked
   } ev_t;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   ev_t  got_q[$];
   ev_t  exp_q[$];
   int   seg_len[$];
   bit   seg_lvl[$];
   logic [7:0] last_pw = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   // Event capture plus always-on output invariants.
   always @(negedge clk) begin
      if (rst) begin
         last_pw = 8'h00;
      end else begin
         total++;
         if (valid === 1'b1 && period_err === 1'b1) begin
            bad++;
            $display("FAIL exclusive valid=%b period_err=%b cyc=%0d", valid, period_err, cyc);
         end
         if (valid === 1'b1) begin
            got_q.push_back('{1'b0, pulse_width, cyc});
            last_pw = pulse_width;
         end else begin
            total++;
            if (pulse_width !== last_pw) begin
               bad++;
               $display("FAIL hold pulse_width=%02h required=%02h cyc=%0d", pulse_width, last_pw, cyc);
            end
         end
         if (period_err === 1'b1) got_q.push_back('{1'b1, 8'h00, cyc});
      end
   end

   task automatic add_seg(input bit lvl, input int len);
      seg_lvl.push_back(lvl);
      seg_len.push_back(len);
   endtask

   task automatic add_period(input int code);
      add_seg(1'b1, code + 1);
      add_seg(1'b0, PER - 1 - code);
   endtask

   // Edge-time model: a rise closes a period only if the previous rise was
   // seen and no timeout happened since; a rise-to-rise gap of TMO with no
   // intervening rise publishes FF or 00 according to the line level.
   task automatic model_build(input int t0);
      int t = t0;
      int ref_t = t0;
      int high_len = 0;
      bit prev, lvl;
      bit have_rise = 1'b0;
      bit timed = 1'b0;
      prev = seg_lvl[0];
      exp_q.delete();
      foreach (seg_len[i]) begin
         lvl = seg_lvl[i];
         if (lvl && !prev) begin
            if (have_rise && !timed) begin
               if (t - ref_t == PER)
                  exp_q.push_back('{1'b0, (high_len > 0) ? 8'(high_len - 1) : 8'h00, t + SYNC + 1});
               else
                  exp_q.push_back('{1'b1, 8'h00, t + SYNC + 1});
            end
            have_rise = 1'b1;
            timed = 1'b0;
            ref_t = t;
         end
         if (!lvl && prev) high_len = t - ref_t;
         if (!timed && ref_t + TMO >= t && ref_t + TMO < t + seg_len[i]) begin
            timed = 1'b1;
            exp_q.push_back('{1'b0, lvl ? 8'hFF : 8'h00, 0});
         end
         prev = lvl;
         t += seg_len[i];
      end
   endtask

   task automatic apply_reset(input bit lvl);
      @(posedge clk); #1;
      rst = 1'b1;
      pulse = lvl;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Must be entered 1 time unit after a rising edge.
   task automatic run_segs(output int t0);
      seg_len[seg_len.size()-1] += 8;
      t0 = cyc;
      got_q.delete();
      model_build(t0);
      foreach (seg_len[i]) begin
         pulse = seg_lvl[i];
         repeat (seg_len[i]) @(posedge clk);
         #1;
      end
      seg_len.delete();
      seg_lvl.delete();
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (pulse_width !== 8'h00) begin bad++; $display("FAIL reset_pw got=%02h exp=00", pulse_width); end
      total++;
      if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
      total++;
      if (period_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", period_err); end
   endtask

   task automatic test_loopback();
      int t0;
      apply_reset(1'b0);
      add_seg(1'b0, 20);
      repeat (5) add_period(100);
      add_seg(1'b1, 5);
      run_segs(t0);
      total++;
      if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL loopback_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         total++;
         if (got_q[i].err !== exp_q[i].err || got_q[i].code !== exp_q[i].code || (exp_q[i].t != 0 && got_q[i].t != exp_q[i].t)) begin
            bad++;
            $display("FAIL loopback_ev%0d got err=%0b code=%02h cyc=%0d exp err=%0b code=%02h cyc=%0d",
                     i, got_q[i].err, got_q[i].code, got_q[i].t, exp_q[i].err, exp_q[i].code, exp_q[i].t);
         end
      end
   endtask

   task automatic test_sweep();
      int t0;
      int codes[$] = '{1, 2, 127, 253, 254};
      repeat (6) codes.push_back(int'($urandom_range(0, 254)));
      apply_reset(1'b0);
      add_seg(1'b0, 20);
      foreach (codes[i]) repeat (3) add_period(codes[i]);
      add_seg(1'b1, 5);
      run_segs(t0);
      total++;
      if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL sweep_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         total++;
         if (got_q[i].err !== exp_q[i].err || got_q[i].code !== exp_q[i].code || (exp_q[i].t != 0 && got_q[i].t != exp_q[i].t)) begin
            bad++;
            $display("FAIL sweep_ev%0d got err=%0b code=%02h cyc=%0d exp err=%0b code=%02h cyc=%0d",
                     i, got_q[i].err, got_q[i].code, got_q[i].t, exp_q[i].err, exp_q[i].code, exp_q[i].t);
         end
      end
   endtask

   task automatic test_stuck_hi();
      int t0, dt;
      apply_reset(1'b0);
      add_seg(1'b0, 20);
      add_seg(1'b1, 600);
      add_seg(1'b0, 30);
      repeat (2) add_period(50);
      add_seg(1'b1, 5);
      run_segs(t0);
      total++;
      if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL stuck_hi_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         total++;
         if (got_q[i].err !== exp_q[i].err || got_q[i].code !== exp_q[i].code || (exp_q[i].t != 0 && got_q[i].t != exp_q[i].t)) begin
            bad++;
            $display("FAIL stuck_hi_ev%0d got err=%0b code=%02h cyc=%0d exp err=%0b code=%02h cyc=%0d",
                     i, got_q[i].err, got_q[i].code, got_q[i].t, exp_q[i].err, exp_q[i].code, exp_q[i].t);
         end
      end
      if (got_q.size() > 0) begin
         dt = got_q[0].t - (t0 + 20);
         total++;
         if (dt < TMO - 2 || dt > TMO + SYNC + 6) begin
            bad++;
            $display("FAIL stuck_hi_delay got=%0d exp=%0d..%0d", dt, TMO - 2, TMO + SYNC + 6);
         end
      end
   endtask

   task automatic test_stuck_lo();
      int t0, dt;
      apply_reset(1'b0);
      add_seg(1'b0, 600);
      repeat (2) add_period(77);
      add_seg(1'b1, 5);
      run_segs(t0);
      total++;
      if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL stuck_lo_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         total++;
         if (got_q[i].err !== exp_q[i].err || got_q[i].code !== exp_q[i].code || (exp_q[i].t != 0 && got_q[i].t != exp_q[i].t)) begin
            bad++;
            $display("FAIL stuck_lo_ev%0d got err=%0b code=%02h cyc=%0d exp err=%0b code=%02h cyc=%0d",
                     i, got_q[i].err, got_q[i].code, got_q[i].t, exp_q[i].err, exp_q[i].code, exp_q[i].t);
         end
      end
      if (got_q.size() > 0) begin
         dt = got_q[0].t - t0;
         total++;
         if (dt < TMO - 4 || dt > TMO + SYNC + 6) begin
            bad++;
            $display("FAIL stuck_lo_delay got=%0d exp=%0d..%0d", dt, TMO - 4, TMO + SYNC + 6);
         end
      end
   endtask

   task automatic test_period_err();
      int t0;
      apply_reset(1'b0);
      add_seg(1'b0, 20);
      add_period(33);
      add_seg(1'b1, 80);
      add_seg(1'b0, 120);
      repeat (2) add_period(10);
      add_seg(1'b1, 5);
      run_segs(t0);
      total++;
      if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL period_err_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         total++;
         if (got_q[i].err !== exp_q[i].err || got_q[i].code !== exp_q[i].code || (exp_q[i].t != 0 && got_q[i].t != exp_q[i].t)) begin
            bad++;
            $display("FAIL period_err_ev%0d got err=%0b code=%02h cyc=%0d exp err=%0b code=%02h cyc=%0d",
                     i, got_q[i].err, got_q[i].code, got_q[i].t, exp_q[i].err, exp_q[i].code, exp_q[i].t);
         end
      end
   endtask

   task automatic test_random_mix();
      int t0, p, h;
      apply_reset(1'b0);
      add_seg(1'b0, 20);
      repeat (14) begin
         if ($urandom_range(0, 3) == 0) begin
            p = int'($urandom_range(60, 480));
            if (p == PER) p = PER + 1;
            h = int'($urandom_range(1, p - 1));
            add_seg(1'b1, h);
            add_seg(1'b0, p - h);
         end else begin
            add_period(int'($urandom_range(0, 254)));
         end
      end
      add_seg(1'b1, 5);
      run_segs(t0);
      total++;
      if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL random_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         total++;
         if (got_q[i].err !== exp_q[i].err || got_q[i].code !== exp_q[i].code || (exp_q[i].t != 0 && got_q[i].t != exp_q[i].t)) begin
            bad++;
            $display("FAIL random_ev%0d got err=%0b code=%02h cyc=%0d exp err=%0b code=%02h cyc=%0d",
                     i, got_q[i].err, got_q[i].code, got_q[i].t, exp_q[i].err, exp_q[i].code, exp_q[i].t);
         end
      end
   endtask

   task automatic test_mid_reset();
      int t0;
      apply_reset(1'b0);
      add_seg(1'b0, 20);
      repeat (2) add_period(100);
      add_seg(1'b1, 40);
      run_segs(t0);
      total++;
      if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL mid_reset_pre_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         total++;
         if (got_q[i].err !== exp_q[i].err || got_q[i].code !== exp_q[i].code || (exp_q[i].t != 0 && got_q[i].t != exp_q[i].t)) begin
            bad++;
            $display("FAIL mid_reset_pre_ev%0d got err=%0b code=%02h cyc=%0d exp err=%0b code=%02h cyc=%0d",
                     i, got_q[i].err, got_q[i].code, got_q[i].t, exp_q[i].err, exp_q[i].code, exp_q[i].t);
         end
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total++;
      if (pulse_width !== 8'h00 || valid !== 1'b0 || period_err !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_outputs got pw=%02h v=%b e=%b exp pw=00 v=0 e=0", pulse_width, valid, period_err);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      add_seg(1'b1, 30);
      add_seg(1'b0, 100);
      repeat (2) add_period(100);
      add_seg(1'b1, 5);
      run_segs(t0);
      total++;
      if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL mid_reset_post_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         total++;
         if (got_q[i].err !== exp_q[i].err || got_q[i].code !== exp_q[i].code || (exp_q[i].t != 0 && got_q[i].t != exp_q[i].t)) begin
            bad++;
            $display("FAIL mid_reset_post_ev%0d got err=%0b code=%02h cyc=%0d exp err=%0b code=%02h cyc=%0d",
                     i, got_q[i].err, got_q[i].code, got_q[i].t, exp_q[i].err, exp_q[i].code, exp_q[i].t);
         end
      end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_sweep();
      test_stuck_hi();
      test_stuck_lo();
      test_period_err();
      test_random_mix();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Receive-side counterpart of the team's 8-bit PWM generator. It samples an asynchronous PWM line, measures the high time and the period, and recovers the 8-bit pulse_width code that produced the waveform. Constant-high and constant-low lines decode to 8'hFF and 8'h00 respectively. It sits at the input pins of the light controller, feeding duty values to downstream logic or to loopback checks against the generator.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on the pulse input (must be at least 2).
PWM_PERIOD, 256, expected period in clk cycles between rising edges.
TIMEOUT, 512, cycles without an edge before the line is declared stuck (must be greater than PWM_PERIOD).

Ports:
clk  input  1  system clock; all logic is on its rising edge.
rst  input  1  synchronous, active-high reset.
pulse  input  1  asynchronous PWM line.
pulse_width  output  8  last decoded duty code; holds its value between updates.
valid  output  1  one-cycle strobe when pulse_width is updated.
period_err  output  1  one-cycle strobe when a measured period is not PWM_PERIOD.

Behaviour:
- Clock is clk. Reset rst is synchronous and active-high.
- Reset values: pulse_width=8'h00, valid=0, period_err=0, synchronizer flops=0, state=IDLE, counter=0.
- s denotes the synchronized input (delayed SYNC_STAGES cycles). rise and fall are single-cycle edge detects on s.
- Counter cnt, width clog2(TIMEOUT+1):
  - Loads 1 on any rise.
  - Otherwise increments each cycle and saturates at TIMEOUT.
- high_cnt equals the number of consecutive cycles with s=1. The period equals the number of cycles from one rise up to, but not including, the next rise.
- States:
  - IDLE: entered from reset. If s=0, go to WAIT_RISE. If s=1 for TIMEOUT cycles, publish 8'hFF and go to STUCK_HI. The first partial pulse after reset is never measured.
  - WAIT_RISE: on rise, go to HIGH. On timeout, publish 8'h00 and go to STUCK_LO.
  - HIGH: on fall, latch high_cnt=cnt and go to LOW. On timeout, publish 8'hFF and go to STUCK_HI.
  - LOW: on rise, check the period (rules below) and go to HIGH. On timeout, publish 8'h00 and go to STUCK_LO.
  - STUCK_HI: on fall, go to WAIT_RISE. No period check is made.
  - STUCK_LO: on rise, go to HIGH.
- Period check on a rise in LOW:
  - If period == PWM_PERIOD: publish max(high_cnt-1, 0). The generator holds the line high for pulse_width+1 cycles, so high_cnt ranges 2..255 and maps to codes 1..254.
  - Otherwise: pulse_err strobes as period_err for one cycle, pulse_width is unchanged, and valid=0.
- "Publish": register the value into pulse_width and assert valid for exactly one cycle in the same cycle the new value appears.
- Latency: valid asserts SYNC_STAGES+1 cycles after the input rising edge that closes a period.
- Timeout fires once per stuck episode. While the line stays stuck, valid is not re-asserted.
- Simultaneous edge and timeout in the same cycle: the edge wins and the timeout is suppressed.
- valid and period_err are never asserted in the same cycle.
- Reset mid-measurement discards all partial counts; the next measurement needs a low, then a rise, then a full period.
- A glitch shorter than one clk cycle may be missed; no filtering is required.

Decomposition:
- Shared package pwm_pkg:
  - PWM_PERIOD (256), PWM_W (8), PWM_MAX (8'hFF), PWM_MIN (8'h00).
  - State enum for the capture FSM, shared so the generator and benches use one period definition.
- One sub-module, pwm_sync_edge: SYNC_STAGES flop synchronizer plus rise/fall detect, with outputs s, rise, fall. Its reset is synchronous and active-high on rst.
- Counter, FSM and output registers live in pwm_capture.

Test Plan:
1. Generator loopback, pulse_width=100 -> high 101 cycles, period 256 -> valid each period with pulse_width=100, period_err=0.
2. Sweep codes 1, 2, 127, 253, 254 -> decoded value equals the driven code on every period after the first full one.
3. pulse held 1 for 600 cycles -> exactly one valid with 8'hFF about 512+SYNC_STAGES cycles after the last edge. Then a falling edge, a rise and a period of 256 with code 50 -> 50.
4. pulse held 0 from reset -> one valid with 8'h00. Then a rise -> state HIGH, and the next full period decodes correctly.
5. Period of 200 cycles with high 80 -> period_err strobe, no valid, pulse_width keeps its previous value. A following correct period with code 10 -> valid, 10.
6. rst asserted mid-HIGH -> all outputs zero next cycle. The first valid after release appears only after a low, a rise and one full 256-cycle period.
